// File: rtl/pcpu_pkg.sv
// -----------------------------------------------------------------------------
// pcpu_pkg
// Shared definitions for the pcpu processor and its host-side program loader:
// default memory geometry, the 5-bit opcode field values found in
// instr[15:11], and the loader sequencing state type.
// -----------------------------------------------------------------------------
package pcpu_pkg;

  localparam int PCPU_ADDR_W = 8;
  localparam int PCPU_DATA_W = 16;

  // Opcode field (instr[15:11]).
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_BZ    = 5'b11010;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,  // host preloads memories, pcpu held in reset
    S_REL   = 3'd1,  // release pcpu reset, enable it
    S_KICK  = 3'd2,  // one-cycle start pulse
    S_RUN   = 3'd3,  // serve fetches and data accesses
    S_DRAIN = 3'd4,  // HALT seen, let the pipeline empty
    S_DONE  = 3'd5   // pcpu stopped, results held in dmem
  } loader_state_t;

endpackage

// File: rtl/pcpu_sram_1r1w.sv
// -----------------------------------------------------------------------------
// pcpu_sram_1r1w
// Register-array memory with one asynchronous read port and one synchronous
// write port. A read of the address being written in the same cycle returns
// the old word; the new word is visible after the clock edge.
//
// Ports:
//   clock  - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
// -----------------------------------------------------------------------------
module pcpu_sram_1r1w #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset branch on purpose; contents must survive a
  // loader reset, and a reset port would prevent mapping to plain storage.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pcpu_program_loader.sv
// -----------------------------------------------------------------------------
// pcpu_program_loader
// Host-side companion of the pcpu pipeline processor. Owns the instruction
// and data memories, accepts a valid/ready host stream to preload them,
// sequences the pcpu reset/enable/start pins and then serves instruction
// fetches and data loads/stores until the run ends.
//
// Sequencing: LOAD -> REL -> KICK -> RUN -> DRAIN -> DONE.
//
// Build option:
//   PCPU_LOADER_HALT_DETECT_EN
//     defined   : fetching a HALT opcode in RUN moves to DRAIN, which keeps
//                 the pcpu enabled for DRAIN_CYCLES cycles before DONE; DONE
//                 waits for host_clear.
//     undefined : RUN persists; host_clear in RUN gives one DONE cycle and
//                 then returns to LOAD.
//
// Ports:
//   clock, reset          - clock; asynchronous active-high reset
//   host_valid/host_ready - preload beat handshake (ready only in LOAD)
//   host_data, host_sel   - beat word; 0 = imem, 1 = dmem
//   host_run              - leave LOAD and start the processor
//   host_clear            - return to LOAD (see build option)
//   cpu_reset/enable/start- pcpu control pins (cpu_reset is active-low there)
//   i_addr, i_datain      - instruction fetch port
//   d_addr, d_dataout,
//   d_we, d_datain        - data load/store port
//   done                  - run finished
//   overflow              - sticky: a load pointer wrapped past the top
// -----------------------------------------------------------------------------
module pcpu_program_loader
  import pcpu_pkg::*;
#(
  parameter int ADDR_W       = PCPU_ADDR_W,
  parameter int DATA_W       = PCPU_DATA_W,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_sel,
  input  logic              host_run,
  input  logic              host_clear,
  output logic              cpu_reset,
  output logic              cpu_enable,
  output logic              cpu_start,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  output logic              done,
  output logic              overflow
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  loader_state_t     state, state_next;
  logic [ADDR_W-1:0] iptr, dptr;
  logic [CNT_W-1:0]  drain_cnt;
  logic              overflow_q;

  logic              beat;
  logic              ptr_clear;
  logic              serving;

  logic              imem_we;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

`ifdef PCPU_LOADER_HALT_DETECT_EN
  logic              halt_fetch;
  assign halt_fetch = (imem_rdata[DATA_W-1 -: 5] == OP_HALT);
`endif

  // ---------------------------------------------------------------------------
  // Memories
  // ---------------------------------------------------------------------------
  pcpu_sram_1r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_imem (
    .clock (clock),
    .we    (imem_we),
    .waddr (iptr),
    .wdata (host_data),
    .raddr (i_addr),
    .rdata (imem_rdata)
  );

  pcpu_sram_1r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dmem (
    .clock (clock),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (d_addr),
    .rdata (dmem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    host_ready = 1'b0;
    cpu_reset  = 1'b1;
    cpu_enable = 1'b0;
    cpu_start  = 1'b0;
    done       = 1'b0;
    serving    = 1'b0;

    case (state)
      S_LOAD: begin
        host_ready = 1'b1;
        cpu_reset  = 1'b0;
        if (host_run) state_next = S_REL;
      end
      S_REL: begin
        cpu_enable = 1'b1;
        serving    = 1'b1;
        state_next = S_KICK;
      end
      S_KICK: begin
        cpu_enable = 1'b1;
        cpu_start  = 1'b1;
        serving    = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        cpu_enable = 1'b1;
        serving    = 1'b1;
`ifdef PCPU_LOADER_HALT_DETECT_EN
        if (halt_fetch) state_next = S_DRAIN;
`else
        if (host_clear) state_next = S_DONE;
`endif
      end
      S_DRAIN: begin
        cpu_enable = 1'b1;
        serving    = 1'b1;
        if (drain_cnt == '0) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
`ifdef PCPU_LOADER_HALT_DETECT_EN
        if (host_clear) state_next = S_LOAD;
`else
        // Only reachable through host_clear in RUN: a single DONE cycle.
        state_next = S_LOAD;
`endif
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  assign beat      = host_valid & host_ready;
  assign ptr_clear = (state == S_DONE) && (state_next == S_LOAD);
  assign imem_we   = beat & ~host_sel;

  // The dmem write port belongs to the host while loading and to the pcpu
  // while it is running; in every other state stores are dropped.
  always_comb begin
    dmem_we    = 1'b0;
    dmem_waddr = dptr;
    dmem_wdata = host_data;
    if (state == S_LOAD) begin
      dmem_we = beat & host_sel;
    end else if ((state == S_RUN) || (state == S_DRAIN)) begin
      dmem_we    = d_we;
      dmem_waddr = d_addr;
      dmem_wdata = d_dataout;
    end
  end

  // Outside the serving window the fetch port returns 0, which decodes as NOP.
  assign i_datain = serving ? imem_rdata : '0;
  assign d_datain = serving ? dmem_rdata : '0;
  assign overflow = overflow_q;

  // ---------------------------------------------------------------------------
  // State, pointers, drain counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_LOAD;
      iptr       <= '0;
      dptr       <= '0;
      overflow_q <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      state <= state_next;

      if (ptr_clear) begin
        iptr <= '0;
        dptr <= '0;
      end else if (beat) begin
        if (host_sel) begin
          dptr <= dptr + 1'b1;
          if (dptr == '1) overflow_q <= 1'b1;
        end else begin
          iptr <= iptr + 1'b1;
          if (iptr == '1) overflow_q <= 1'b1;
        end
      end

      // Held at its start value outside DRAIN, so entry always begins a
      // full DRAIN_CYCLES-long window.
      if (state != S_DRAIN) begin
        drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
      end else if (drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcpu_program_loader.sv
// -----------------------------------------------------------------------------
// tb_pcpu_program_loader
// Self-checking bench for pcpu_program_loader. Keeps its own model of both
// memories, the load pointers and the overflow flag; expected read data is
// queued when an address is driven and compared when the output is sampled.
// Inputs change 1 time unit after a rising edge, outputs are sampled 1 time
// unit later.
// -----------------------------------------------------------------------------
module tb_pcpu_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [15:0] host_data = '0;
  logic        host_sel = 1'b0;
  logic        host_run = 1'b0;
  logic        host_clear = 1'b0;
  logic        cpu_reset, cpu_enable, cpu_start;
  logic [7:0]  i_addr = '0;
  logic [15:0] i_datain;
  logic [7:0]  d_addr = '0;
  logic [15:0] d_dataout = '0;
  logic        d_we = 1'b0;
  logic [15:0] d_datain;
  logic        done, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model_imem [256];
  logic [15:0] model_dmem [256];
  int          model_iptr = 0;
  int          model_dptr = 0;
  logic        model_ovf  = 1'b0;
  logic [15:0] exp_q [$];

  // {cpu_reset, cpu_enable, cpu_start, host_ready, done}
  localparam logic [4:0] ST_LOAD = 5'b00010;
  localparam logic [4:0] ST_REL  = 5'b11000;
  localparam logic [4:0] ST_KICK = 5'b11100;
  localparam logic [4:0] ST_RUN  = 5'b11000;
  localparam logic [4:0] ST_DONE = 5'b10001;

  pcpu_program_loader dut (
    .clock      (clock),
    .reset      (reset),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .host_sel   (host_sel),
    .host_run   (host_run),
    .host_clear (host_clear),
    .cpu_reset  (cpu_reset),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .d_addr     (d_addr),
    .d_dataout  (d_dataout),
    .d_we       (d_we),
    .d_datain   (d_datain),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] status();
    return {cpu_reset, cpu_enable, cpu_start, host_ready, done};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic sel, input logic [15:0] data);
    host_valid = 1'b1;
    host_sel   = sel;
    host_data  = data;
    tick();
    host_valid = 1'b0;
    if (sel) begin
      model_dmem[model_dptr] = data;
      if (model_dptr == 255) model_ovf = 1'b1;
      model_dptr = (model_dptr + 1) % 256;
    end else begin
      model_imem[model_iptr] = data;
      if (model_iptr == 255) model_ovf = 1'b1;
      model_iptr = (model_iptr + 1) % 256;
    end
  endtask

  // LOAD -> REL -> KICK -> RUN, no checks.
  task automatic run_start();
    host_run = 1'b1;
    tick();
    host_run = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] exp_d;
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (status() !== ST_LOAD || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b ovf=%b expected %b ovf=0", status(), overflow, ST_LOAD);
    end
    reset = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    exp_d = exp_q.pop_front();
    n_tests++;
    if (status() !== ST_LOAD || i_datain !== exp_d || dut.iptr !== 8'd0 || dut.dptr !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_release: got st=%b i_datain=%h iptr=%0d dptr=%0d expected st=%b i_datain=%h ptrs 0",
               status(), i_datain, dut.iptr, dut.dptr, ST_LOAD, exp_d);
    end
  endtask

  task automatic test_load();
    send_beat(1'b0, 16'h4935);
    send_beat(1'b0, 16'h4A66);
    send_beat(1'b0, 16'h0800);
    send_beat(1'b1, 16'h1111);
    send_beat(1'b1, 16'h2222);
    #1;
    n_tests++;
    if (dut.iptr !== 8'(model_iptr) || dut.dptr !== 8'(model_dptr)) begin
      n_fail++;
      $display("FAIL load_ptrs: got iptr=%0d dptr=%0d expected iptr=%0d dptr=%0d",
               dut.iptr, dut.dptr, model_iptr, model_dptr);
    end
    // A beat without host_valid must not move a pointer.
    host_data = 16'hDEAD;
    tick();
    n_tests++;
    if (dut.iptr !== 8'(model_iptr) || overflow !== model_ovf) begin
      n_fail++;
      $display("FAIL idle_no_beat: got iptr=%0d ovf=%b expected iptr=%0d ovf=%b",
               dut.iptr, overflow, model_iptr, model_ovf);
    end
  endtask

  task automatic test_run_seq();
    host_run = 1'b1;
    #1;
    n_tests++;
    if (status() !== ST_LOAD) begin
      n_fail++;
      $display("FAIL seq_load: got %b expected %b", status(), ST_LOAD);
    end
    tick();
    host_run = 1'b0;
    #1;
    n_tests++;
    if (status() !== ST_REL) begin
      n_fail++;
      $display("FAIL seq_rel: got %b expected %b", status(), ST_REL);
    end
    tick();
    n_tests++;
    if (status() !== ST_KICK) begin
      n_fail++;
      $display("FAIL seq_kick: got %b expected %b", status(), ST_KICK);
    end
    tick();
    n_tests++;
    if (status() !== ST_RUN) begin
      n_fail++;
      $display("FAIL seq_run: got %b expected %b", status(), ST_RUN);
    end
  endtask

  task automatic test_fetch();
    logic [15:0] exp_d;
    for (int a = 0; a < 3; a++) begin
      i_addr = 8'(a);
      exp_q.push_back(model_imem[a]);
      #1;
      exp_d = exp_q.pop_front();
      n_tests++;
      if (i_datain !== exp_d) begin
        n_fail++;
        $display("FAIL fetch_%0d: got %h expected %h", a, i_datain, exp_d);
      end
    end
    i_addr = 8'd0;
  endtask

  task automatic test_store();
    logic [15:0] exp_d;
    // Same-cycle read of the address being stored returns the old word.
    d_addr = 8'h01; d_dataout = 16'h3333; d_we = 1'b1;
    exp_q.push_back(model_dmem[1]);
    #1;
    exp_d = exp_q.pop_front();
    n_tests++;
    if (d_datain !== exp_d) begin
      n_fail++;
      $display("FAIL store_old_data: got %h expected %h", d_datain, exp_d);
    end
    tick();
    model_dmem[1] = 16'h3333;
    d_addr = 8'h10; d_dataout = 16'hBEEF;
    exp_q.push_back(model_dmem[1]);
    tick();
    model_dmem[8'h10] = 16'hBEEF;
    d_we = 1'b0;
    exp_q.push_back(model_dmem[8'h10]);
    #1;
    exp_d = exp_q.pop_front();
    n_tests++;
    if (dut.u_dmem.mem[1] !== exp_d) begin
      n_fail++;
      $display("FAIL store_word1: got %h expected %h", dut.u_dmem.mem[1], exp_d);
    end
    exp_d = exp_q.pop_front();
    n_tests++;
    if (d_datain !== exp_d) begin
      n_fail++;
      $display("FAIL store_beef: got %h expected %h", d_datain, exp_d);
    end
  endtask

  task automatic test_end_run();
    logic [15:0] exp_d;
`ifdef PCPU_LOADER_HALT_DETECT_EN
    i_addr = 8'd2;
    exp_q.push_back(model_imem[2]);
    #1;
    exp_d = exp_q.pop_front();
    n_tests++;
    if (i_datain !== exp_d) begin
      n_fail++;
      $display("FAIL halt_fetch: got %h expected %h", i_datain, exp_d);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_tests++;
      if (status() !== ST_RUN) begin
        n_fail++;
        $display("FAIL drain_cycle_%0d: got %b expected %b", c, status(), ST_RUN);
      end
    end
    tick();
    i_addr = 8'd0;
    #1;
    n_tests++;
    if (status() !== ST_DONE) begin
      n_fail++;
      $display("FAIL halt_done: got %b expected %b", status(), ST_DONE);
    end
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    #1;
`else
    // A HALT word must not end the run in this build.
    i_addr = 8'd2;
    tick();
    tick();
    n_tests++;
    if (status() !== ST_RUN) begin
      n_fail++;
      $display("FAIL halt_ignored: got %b expected %b", status(), ST_RUN);
    end
    i_addr = 8'd0;
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    #1;
    n_tests++;
    if (status() !== ST_DONE) begin
      n_fail++;
      $display("FAIL clear_done: got %b expected %b", status(), ST_DONE);
    end
    tick();
`endif
    model_iptr = 0;
    model_dptr = 0;
    exp_q.push_back(16'h0000);
    exp_d = exp_q.pop_front();
    n_tests++;
    if (status() !== ST_LOAD || dut.iptr !== 8'd0 || dut.dptr !== 8'd0 || i_datain !== exp_d) begin
      n_fail++;
      $display("FAIL clear_to_load: got st=%b iptr=%0d dptr=%0d i_datain=%h expected st=%b ptrs 0 i_datain=%h",
               status(), dut.iptr, dut.dptr, i_datain, ST_LOAD, exp_d);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_d;
    for (int i = 0; i < 257; i++) begin
      if (i == 255) begin
        n_tests++;
        if (overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_early: got overflow=%b expected 0", overflow);
        end
      end
      send_beat(1'b1, 16'h5000 + 16'(i));
    end
    #1;
    n_tests++;
    if (overflow !== model_ovf || dut.dptr !== 8'(model_dptr) || dut.iptr !== 8'(model_iptr)) begin
      n_fail++;
      $display("FAIL wrap_ptrs: got ovf=%b dptr=%0d iptr=%0d expected ovf=%b dptr=%0d iptr=%0d",
               overflow, dut.dptr, dut.iptr, model_ovf, model_dptr, model_iptr);
    end
    run_start();
    for (int k = 0; k < 2; k++) begin
      d_addr = (k == 0) ? 8'h00 : 8'hFF;
      exp_q.push_back(model_dmem[d_addr]);
      #1;
      exp_d = exp_q.pop_front();
      n_tests++;
      if (d_datain !== exp_d) begin
        n_fail++;
        $display("FAIL wrap_dmem_%h: got %h expected %h", d_addr, d_datain, exp_d);
      end
    end
    d_addr = 8'h00;
  endtask

  task automatic test_reset_midrun();
    logic [15:0] exp_d;
    n_tests++;
    if (status() !== ST_RUN) begin
      n_fail++;
      $display("FAIL midrun_precond: got %b expected %b", status(), ST_RUN);
    end
    reset = 1'b1;
    #1;
    model_iptr = 0;
    model_dptr = 0;
    model_ovf  = 1'b0;
    n_tests++;
    if (status() !== ST_LOAD || dut.iptr !== 8'd0 || dut.dptr !== 8'd0 || overflow !== model_ovf) begin
      n_fail++;
      $display("FAIL midrun_reset: got st=%b iptr=%0d dptr=%0d ovf=%b expected st=%b ptrs 0 ovf=0",
               status(), dut.iptr, dut.dptr, overflow, ST_LOAD);
    end
    #2;
    reset = 1'b0;
    tick();
    run_start();
    i_addr = 8'd1;
    d_addr = 8'd0;
    exp_q.push_back(model_imem[1]);
    exp_q.push_back(model_dmem[0]);
    #1;
    exp_d = exp_q.pop_front();
    n_tests++;
    if (i_datain !== exp_d) begin
      n_fail++;
      $display("FAIL midrun_imem_kept: got %h expected %h", i_datain, exp_d);
    end
    exp_d = exp_q.pop_front();
    n_tests++;
    if (d_datain !== exp_d) begin
      n_fail++;
      $display("FAIL midrun_dmem_kept: got %h expected %h", d_datain, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_seq();
    test_fetch();
    test_store();
    test_end_run();
    test_wrap();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
